// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction width, opcode field position,
// the HALT opcode and the fetch-state encoding.
package pipe_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;

    localparam logic [OP_HI-OP_LO:0] OP_HALT = 4'hF;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    // Opcode field of an instruction word.
    function automatic logic [OP_HI-OP_LO:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and an
// asynchronous-read instruction memory (slave).
interface if_stage_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0]             imem_addr;
    logic [pipe_pkg::INSTR_W-1:0] imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble and beats enable;
// when enabled without load (fetch halted) the word and its address are
// kept for visibility but marked invalid.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    // Next-value selection: flush, then enabled load / bubble, else hold.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (en) begin
            if (load) begin
                instr_d = instr_in;
                pc_d    = pc_in;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = pc_q;
    assign instr_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC mux, fetch FSM and
// the IF/ID register instance.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   FS_RUN    | fetching one word per cycle, pc advances unless stalled
//   FS_HALTED | HALT was delivered; pc frozen, bubbles until redirect
module if_stage
    import pipe_pkg::*;
#(
    parameter int                    PC_W     = 8,
    parameter logic [PC_W-1:0]       RESET_PC = '0,
    parameter logic [OP_HI-OP_LO:0]  HALT_OP  = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    if_stage_if.master         imem,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            is_halt;

    assign imem.imem_addr = pc_q;
    assign is_halt        = (get_opcode(imem.imem_data) == HALT_OP);

    // Next PC and state: redirect beats stall; HALT is only seen on a real fetch.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = FS_RUN;
        end else if (!stall && state_q == FS_RUN) begin
            if (is_halt) begin
                state_d = FS_HALTED;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
        halted_d = (state_d == FS_HALTED);
    end

    // Fetch FSM, PC and registered halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FS_RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .en          (!stall),
        .flush       (redirect_valid),
        .load        (state_q == FS_RUN),
        .instr_in    (imem.imem_data),
        .pc_in       (pc_q),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an asynchronous-read instruction memory.
module tb_if_stage;
    import pipe_pkg::*;

    localparam int PC_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [15:0]      instr;
    logic [PC_W-1:0]  instr_pc;
    logic             instr_valid;
    logic             halted;

    logic [15:0]      mem [0:255];

    int total = 0;
    int bad   = 0;

    if_stage_if #(.PC_W(PC_W)) bus ();

    assign bus.imem_data = mem[bus.imem_addr];

    if_stage #(
        .PC_W     (PC_W),
        .RESET_PC (8'h00),
        .HALT_OP  (4'hF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the full observable state after an edge.
    task automatic expect_all(input string tag, input logic [15:0] e_instr,
                              input logic [7:0] e_pc, input logic e_valid,
                              input logic e_halted, input logic [7:0] e_addr);
        chk({tag, ".instr"},    32'(instr),         32'(e_instr));
        chk({tag, ".instr_pc"}, 32'(instr_pc),      32'(e_pc));
        chk({tag, ".valid"},    32'(instr_valid),   32'(e_valid));
        chk({tag, ".halted"},   32'(halted),        32'(e_halted));
        chk({tag, ".addr"},     32'(bus.imem_addr), 32'(e_addr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1000;
        mem[8'h01] = 16'h2400;
        mem[8'h02] = 16'h3800;
        mem[8'h03] = 16'h0000;
        mem[8'h04] = 16'h5123;
        mem[8'h05] = 16'hF000;
        mem[8'h10] = 16'h7010;
        mem[8'h40] = 16'h4444;
        mem[8'h41] = 16'h4545;
        mem[8'hFE] = 16'h1FE0;
        mem[8'hFF] = 16'h2FF0;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        step();
        expect_all("reset", 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;

        // Free-run over mem[0..2].
        step(); expect_all("run0", 16'h1000, 8'h00, 1'b1, 1'b0, 8'h01);
        step(); expect_all("run1", 16'h2400, 8'h01, 1'b1, 1'b0, 8'h02);
        step(); expect_all("run2", 16'h3800, 8'h02, 1'b1, 1'b0, 8'h03);

        // Stall for three cycles while instr_pc=2.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_all("stall", 16'h3800, 8'h02, 1'b1, 1'b0, 8'h03);
        end
        stall = 1'b0;
        step(); expect_all("resume3", 16'h0000, 8'h03, 1'b1, 1'b0, 8'h04);
        step(); expect_all("run4",    16'h5123, 8'h04, 1'b1, 1'b0, 8'h05);

        // HALT at address 5: delivered once, then bubbles with pc frozen.
        step(); expect_all("halt_dlv", 16'hF000, 8'h05, 1'b1, 1'b1, 8'h05);
        step(); expect_all("halted1",  16'hF000, 8'h05, 1'b0, 1'b1, 8'h05);
        step(); expect_all("halted2",  16'hF000, 8'h05, 1'b0, 1'b1, 8'h05);

        // Redirect out of HALTED.
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        step(); expect_all("rd_halt_bub", 16'h0000, 8'h05, 1'b0, 1'b0, 8'h10);
        redirect_valid = 1'b0;
        step(); expect_all("rd_halt_tgt", 16'h7010, 8'h10, 1'b1, 1'b0, 8'h11);

        // Redirect together with stall: redirect wins.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h40;
        step();
        chk("rd_stall.addr",  32'(bus.imem_addr), 32'h40);
        chk("rd_stall.valid", 32'(instr_valid),   32'h0);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); expect_all("rd_tgt40", 16'h4444, 8'h40, 1'b1, 1'b0, 8'h41);
        step(); expect_all("rd_tgt41", 16'h4545, 8'h41, 1'b1, 1'b0, 8'h42);

        // PC wrap from FF to 00.
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step(); chk("wrap_bub.valid", 32'(instr_valid), 32'h0);
        redirect_valid = 1'b0;
        step(); expect_all("wrapFE", 16'h1FE0, 8'hFE, 1'b1, 1'b0, 8'hFF);
        step(); expect_all("wrapFF", 16'h2FF0, 8'hFF, 1'b1, 1'b0, 8'h00);
        step(); expect_all("wrap00", 16'h1000, 8'h00, 1'b1, 1'b0, 8'h01);
        step(); expect_all("wrap01", 16'h2400, 8'h01, 1'b1, 1'b0, 8'h02);

        // Reset while halted, with a redirect and stall pending.
        redirect_valid = 1'b1; redirect_pc = 8'h05;
        step();
        redirect_valid = 1'b0;
        step(); expect_all("halt2_dlv", 16'hF000, 8'h05, 1'b1, 1'b1, 8'h05);
        rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h40;
        step(); expect_all("rst_mid", 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        step(); expect_all("post_rst", 16'h1000, 8'h00, 1'b1, 1'b0, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
